demorgan_sweep_driver: RTL and testbench

//  Sequential stimulus/checker stage that feeds the two-input demorgan gate block and consumes its eight outputs.
//  On start it sweeps A,B through 00,01,10,11 for PASSES sweeps, waits SETTLE_CYCLES per vector, then samples the outputs.
//  It checks each sample against a golden model and streams one result record per vector to a downstream logger (valid/ready).
//  It ends with a one-cycle done pulse and a pass/fail summary.

---
 rtl/demorgan_pkg.sv | 33 +++
 rtl/demorgan_expect.sv | 29 ++
 rtl/demorgan_sweep_driver.sv | 126 ++++++++++++
 tb/tb_demorgan_sweep_driver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demorgan_pkg.sv
// ------------------------------------------------------------------
// demorgan_pkg: shared types and constants for the demorgan sweep stage
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package demorgan_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Bit positions of the gate block outputs
  localparam int NA      = 7;
  localparam int NB      = 6;
  localparam int NANDNB  = 5;
  localparam int AANDB   = 4;
  localparam int NAB     = 3;
  localparam int NAORNB  = 2;
  localparam int AORB    = 1;
  localparam int NAORB   = 0;

  localparam int NUM_VECTORS = 4;
  localparam int RES_W       = 11;

endpackage

`default_nettype wire

// File: rtl/demorgan_expect.sv
// ------------------------------------------------------------------
// demorgan_expect: golden 8-bit output vector of the two-input gate block
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module demorgan_expect
  import demorgan_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] expected
);

  always_comb begin
    expected         = '0;
    expected[NA]     = ~a;
    expected[NB]     = ~b;
    expected[NANDNB] = ~a & ~b;
    expected[AANDB]  = a & b;
    expected[NAB]    = ~(a & b);
    expected[NAORNB] = ~a | ~b;
    expected[AORB]   = a | b;
    expected[NAORB]  = ~(a | b);
  end

endmodule

`default_nettype wire

// File: rtl/demorgan_sweep_driver.sv
// ------------------------------------------------------------------
// demorgan_sweep_driver: sweeps A,B over all vectors, checks the gate block, streams results
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module demorgan_sweep_driver
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic [7:0]       dut_out,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [3:0]       err_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data
);

  localparam int         VIDX_W      = $clog2(NUM_VECTORS);
  localparam logic [VIDX_W-1:0] LAST_VEC = VIDX_W'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LAST_PASS   = 4'(PASSES - 1);

  state_t            state;
  logic [VIDX_W-1:0] vidx;
  logic [3:0]        pidx;
  logic [3:0]        settle;
  logic [7:0]        expected;
  logic              mismatch;

  demorgan_expect u_expect (
    .a        (dut_a),
    .b        (dut_b),
    .expected (expected)
  );

  // Simulation treats X/Z on the gate outputs as a failure
`ifdef SYNTHESIS
  assign mismatch = (dut_out != expected);
`else
  assign mismatch = (dut_out !== expected);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      vidx      <= '0;
      pidx      <= '0;
      settle    <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      all_pass  <= 1'b0;
      err_count <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_APPLY;
            busy      <= 1'b1;
            err_count <= '0;
            all_pass  <= 1'b0;
            vidx      <= '0;
            pidx      <= '0;
          end
        end
        S_APPLY: begin
          {dut_a, dut_b} <= vidx;
          settle         <= SETTLE_LOAD;
          state          <= S_SETTLE;
        end
        S_SETTLE: begin
          settle <= settle - 4'd1;
          if (settle == 4'd1) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          res_data  <= {mismatch, dut_a, dut_b, dut_out};
          res_valid <= 1'b1;
          if (mismatch && (err_count != 4'hF)) err_count <= err_count + 4'd1;
          state     <= S_REPORT;
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (vidx == LAST_VEC) begin
              vidx <= '0;
              if (pidx == LAST_PASS) begin
                // Raise done and the verdict together so they are seen in the same cycle
                state    <= S_DONE;
                done     <= 1'b1;
                all_pass <= (err_count == 4'd0);
              end else begin
                pidx  <= pidx + 4'd1;
                state <= S_APPLY;
              end
            end else begin
              vidx  <= vidx + VIDX_W'(1);
              state <= S_APPLY;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_demorgan_sweep_driver.sv
// ------------------------------------------------------------------
// tb_demorgan_sweep_driver: randomized self-checking bench for the sweep driver
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_demorgan_sweep_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sel;
  logic       start;
  logic       ready;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [7:0] golden(input logic a, input logic b);
    return {~a, ~b, ~a & ~b, a & b, ~(a & b), ~a | ~b, a | b, ~(a | b)};
  endfunction

  // Instance 0: default parameters; instance 1: long sweep with longer settle
  logic        a0, b0, busy0, done0, ap0, valid0;
  logic [3:0]  err0;
  logic [10:0] data0;
  logic [7:0]  out0;
  logic        a1, b1, busy1, done1, ap1, valid1;
  logic [3:0]  err1;
  logic [10:0] data1;
  logic [7:0]  out1;

  assign out0 = (golden(a0, b0) | set_mask) & ~clr_mask;
  assign out1 = (golden(a1, b1) | set_mask) & ~clr_mask;

  demorgan_sweep_driver u_dut (
    .clk(clk), .reset(reset), .start(start & ~sel),
    .dut_a(a0), .dut_b(b0), .dut_out(out0),
    .busy(busy0), .done(done0), .all_pass(ap0), .err_count(err0),
    .res_valid(valid0), .res_ready(sel ? 1'b1 : ready), .res_data(data0)
  );

  demorgan_sweep_driver #(.SETTLE_CYCLES(3), .PASSES(15)) u_dut_big (
    .clk(clk), .reset(reset), .start(start & sel),
    .dut_a(a1), .dut_b(b1), .dut_out(out1),
    .busy(busy1), .done(done1), .all_pass(ap1), .err_count(err1),
    .res_valid(valid1), .res_ready(sel ? ready : 1'b1), .res_data(data1)
  );

  wire        busy_s  = sel ? busy1  : busy0;
  wire        done_s  = sel ? done1  : done0;
  wire        ap_s    = sel ? ap1    : ap0;
  wire        valid_s = sel ? valid1 : valid0;
  wire [3:0]  err_s   = sel ? err1   : err0;
  wire [10:0] data_s  = sel ? data1  : data0;
  wire        a_s     = sel ? a1     : a0;
  wire        b_s     = sel ? b1     : b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete run: model builds the expected record stream, then the run is consumed
  task automatic run_sweep(input int passes, input int settle, input int stall_first,
                           input bit rnd_ready, input bit hold_start);
    logic [10:0] expq[$];
    logic [10:0] held;
    logic [10:0] exp_rec;
    logic [1:0]  vv;
    logic [7:0]  o;
    logic        m;
    int          mism_total;
    int          exp_err;
    int          cyc;
    int          stalls;
    int          budget;
    bit          pending;
    mism_total = 0;
    stalls     = 0;
    pending    = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        vv = 2'(v);
        o  = (golden(vv[1], vv[0]) | set_mask) & ~clr_mask;
        m  = (o != golden(vv[1], vv[0]));
        expq.push_back({m, vv, o});
        mism_total += int'(m);
      end
    end
    exp_err = (mism_total > 15) ? 15 : mism_total;
    budget  = passes * 4 * (settle + 3) * 3 + stall_first + 40;

    start = 1'b1;
    ready = 1'b1;
    tick();
    cyc = 1;
    if (!hold_start) start = 1'b0;
    tests_run++;
    if (busy_s !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_start: got %b want 1", busy_s);
    end

    while (done_s !== 1'b1 && cyc < budget) begin
      if (valid_s === 1'b1) begin
        if (pending) begin
          tests_run++;
          if (data_s !== held) begin
            tests_failed++;
            $display("FAIL res_data_stable: got %h want %h", data_s, held);
          end
        end
        if (stall_first > 0) begin
          ready = 1'b0;
          stall_first--;
        end else begin
          ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (ready) begin
          pending = 1'b0;
          tests_run++;
          if (expq.size() == 0) begin
            tests_failed++;
            $display("FAIL extra_record: got %h want none", data_s);
          end else begin
            exp_rec = expq.pop_front();
            if (data_s !== exp_rec) begin
              tests_failed++;
              $display("FAIL record: got %h want %h", data_s, exp_rec);
            end
          end
        end else begin
          pending = 1'b1;
          held    = data_s;
          stalls++;
        end
      end else begin
        pending = 1'b0;
        ready   = 1'b1;
      end
      tick();
      cyc++;
    end
    ready = 1'b1;

    tests_run++;
    if (done_s !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_timeout: got no done after %0d cycles want done", cyc);
    end else begin
      tests_run++;
      if (cyc != passes * 4 * (settle + 3) + 1 + stalls) begin
        tests_failed++;
        $display("FAIL done_cycle: got %0d want %0d", cyc, passes * 4 * (settle + 3) + 1 + stalls);
      end
    end
    tests_run++;
    if (expq.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_records: got %0d left want 0", expq.size());
    end
    tests_run++;
    if (err_s !== 4'(exp_err)) begin
      tests_failed++;
      $display("FAIL err_count: got %0d want %0d", err_s, exp_err);
    end
    tick();
    tests_run++;
    if (done_s !== 1'b0 || busy_s !== 1'b0 || ap_s !== (mism_total == 0)) begin
      tests_failed++;
      $display("FAIL post_done: got done=%b busy=%b all_pass=%b want done=0 busy=0 all_pass=%b",
               done_s, busy_s, ap_s, (mism_total == 0));
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if ({a0, b0, busy0, done0, ap0, err0, valid0, data0} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want 0", {a0, b0, busy0, done0, ap0, err0, valid0, data0});
    end
  endtask

  task automatic test_nominal;
    sel = 1'b0; set_mask = 8'h00; clr_mask = 8'h00;
    run_sweep(1, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_fault;
    sel = 1'b0; set_mask = 8'h01; clr_mask = 8'h00;
    run_sweep(1, 1, 0, 1'b0, 1'b0);
    tests_run++;
    if (err0 !== 4'd3 || ap0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL stuck_fault: got err=%0d all_pass=%b want err=3 all_pass=0", err0, ap0);
    end
    set_mask = 8'h00;
  endtask

  task automatic test_backpressure;
    sel = 1'b0; set_mask = 8'h00; clr_mask = 8'h00;
    run_sweep(1, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_saturate;
    sel = 1'b1; set_mask = 8'h00; clr_mask = 8'hFF;
    run_sweep(15, 3, 0, 1'b1, 1'b0);
    tests_run++;
    if (err1 !== 4'd15) begin
      tests_failed++;
      $display("FAIL saturate: got %0d want 15", err1);
    end
    sel = 1'b0; clr_mask = 8'h00;
  endtask

  task automatic test_reset_midrun;
    sel = 1'b0; set_mask = 8'h00; clr_mask = 8'h80;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    tests_run++;
    if (a0 !== 1'b1 || b0 !== 1'b0 || busy0 !== 1'b1 || err0 !== 4'd2) begin
      tests_failed++;
      $display("FAIL pre_reset: got a=%b b=%b busy=%b err=%0d want a=1 b=0 busy=1 err=2",
               a0, b0, busy0, err0);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (busy0 !== 1'b0 || valid0 !== 1'b0 || a0 !== 1'b0 || b0 !== 1'b0 || err0 !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got busy=%b valid=%b a=%b b=%b err=%0d want all 0",
               busy0, valid0, a0, b0, err0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    clr_mask = 8'h00;
    run_sweep(1, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_held;
    int cyc;
    sel = 1'b0; set_mask = 8'h00; clr_mask = 8'h00;
    run_sweep(1, 1, 0, 1'b0, 1'b1);
    tick();
    tests_run++;
    if (busy0 !== 1'b1 || ap0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart: got busy=%b all_pass=%b want busy=1 all_pass=0", busy0, ap0);
    end
    start = 1'b0;
    cyc = 1;
    while (done0 !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (cyc != 17) begin
      tests_failed++;
      $display("FAIL second_run_done: got cycle %0d want 17", cyc);
    end
    tick();
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      sel      = 1'b0;
      set_mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      clr_mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom) & ~set_mask;
      run_sweep(1, 1, int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end
    sel      = 1'b1;
    set_mask = 8'($urandom);
    clr_mask = 8'h00;
    run_sweep(15, 3, 0, 1'b1, 1'b0);
    sel = 1'b0; set_mask = 8'h00;
  endtask

  initial begin
    reset    = 1'b1;
    sel      = 1'b0;
    start    = 1'b0;
    ready    = 1'b1;
    set_mask = 8'h00;
    clr_mask = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    test_nominal();
    test_stuck_fault();
    test_backpressure();
    test_saturate();
    test_reset_midrun();
    test_start_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
